// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// The arbiter takes the slave view; whoever drives the requests takes the master view.
interface rr_arbiter_4_if;
  logic       en;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  modport master (
    output en,
    output req,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  timeout
  );

  modport slave (
    input  en,
    input  req,
    output grant,
    output grant_idx,
    output grant_valid,
    output timeout
  );
endinterface

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with a hold-time limit; every output is registered
// and the one-hot grant is the enabled decode of the registered winner index.
module rr_arbiter_4 #(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 5
) (
  input logic          clk,
  input logic          rst_n,
  rr_arbiter_4_if.slave arb
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           state, state_nxt;
  logic [1:0]       last, last_nxt;
  logic [1:0]       idx_q, idx_nxt;
  logic             valid_q, valid_nxt;
  logic             timeout_q, timeout_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       grant_q, grant_nxt;
  logic [2:0]       pick_all, pick_other;

  function automatic logic [3:0] decode(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Returns {found, index}; walks last+1, last+2, ... wrapping, and finishes on
  // last itself, so the most recent winner has the lowest priority.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] from);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = from + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // In GRANT, last always equals idx_q; masking the holder gives the timeout search.
  assign pick_all   = rr_pick(arb.req, last);
  assign pick_other = rr_pick(arb.req & ~decode(idx_q), last);

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    last_nxt    = last;
    idx_nxt     = idx_q;
    valid_nxt   = 1'b0;
    timeout_nxt = 1'b0;
    cnt_nxt     = cnt;

    unique case (state)
      IDLE: begin
        if (arb.en && pick_all[2]) begin
          state_nxt = GRANT;
          last_nxt  = pick_all[1:0];
          idx_nxt   = pick_all[1:0];
          valid_nxt = 1'b1;
          cnt_nxt   = '0;
        end
      end

      GRANT: begin
        if (!arb.en) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (!arb.req[idx_q]) begin
          // Holder released: hand over in the same cycle so no idle bubble appears.
          if (pick_all[2]) begin
            last_nxt  = pick_all[1:0];
            idx_nxt   = pick_all[1:0];
            valid_nxt = 1'b1;
            cnt_nxt   = '0;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end else if (cnt == HOLD_LAST) begin
          timeout_nxt = 1'b1;
          valid_nxt   = 1'b1;
          cnt_nxt     = '0;
          if (pick_other[2]) begin
            last_nxt = pick_other[1:0];
            idx_nxt  = pick_other[1:0];
          end
        end else begin
          valid_nxt = 1'b1;
          cnt_nxt   = cnt + 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase

    grant_nxt = decode(idx_nxt) & {4{valid_nxt}};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 2'd3;
      idx_q     <= 2'd0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt       <= '0;
      grant_q   <= 4'b0000;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      idx_q     <= idx_nxt;
      valid_q   <= valid_nxt;
      timeout_q <= timeout_nxt;
      cnt       <= cnt_nxt;
      grant_q   <= grant_nxt;
    end
  end

  assign arb.grant       = grant_q;
  assign arb.grant_idx   = idx_q;
  assign arb.grant_valid = valid_q;
  assign arb.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4: the driver queues the hand-computed outputs
// expected after each clock edge, and a monitor pops and compares them.
module tb_rr_arbiter_4;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] idx;
    logic       valid;
    logic       timeout;
  } obs_t;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  obs_t  exp_q[$];
  string name_q[$];

  rr_arbiter_4_if bus ();

  rr_arbiter_4 #(
    .HOLD_MAX(16),
    .CNT_W   (5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .arb  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic obs_t mk(input logic [3:0] g, input logic [1:0] i, input logic t);
    obs_t o;
    o.grant   = g;
    o.idx     = i;
    o.valid   = |g;
    o.timeout = t;
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.grant   = bus.grant;
    o.idx     = bus.grant_idx;
    o.valid   = bus.grant_valid;
    o.timeout = bus.timeout;
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s @%0t: got grant=%b idx=%0d valid=%b timeout=%b, want grant=%b idx=%0d valid=%b timeout=%b",
               name, $time, act.grant, act.idx, act.valid, act.timeout,
               exp.grant, exp.idx, exp.valid, exp.timeout);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
  task automatic step(input logic e, input logic [3:0] r, input logic [3:0] g,
                      input logic [1:0] i, input logic t, input string name);
    @(negedge clk);
    bus.en  = e;
    bus.req = r;
    exp_q.push_back(mk(g, i, t));
    name_q.push_back(name);
  endtask

  initial begin : monitor
    obs_t  e;
    string n;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, observe(), e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    total   = 0;
    passed  = 0;
    rst_n   = 1'b1;
    bus.en  = 1'b0;
    bus.req = 4'b0000;
    #2 rst_n = 1'b0;
    #1 check("reset_state", observe(), mk(4'b0000, 2'd0, 1'b0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "idle_no_req");
    step(1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0, "idle_en_low");

    // Rotation 0,1,2,3,0 as each holder releases.
    step(1'b1, 4'b1111, 4'b0001, 2'd0, 1'b0, "t1_first_grant");
    step(1'b1, 4'b1110, 4'b0010, 2'd1, 1'b0, "t1_grant1");
    step(1'b1, 4'b1100, 4'b0100, 2'd2, 1'b0, "t1_grant2");
    step(1'b1, 4'b1000, 4'b1000, 2'd3, 1'b0, "t1_grant3");
    step(1'b1, 4'b0111, 4'b0001, 2'd0, 1'b0, "t1_wrap0");
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, "t1_release_all");

    // Lone requester: timeout after 16 grant cycles, same requester re-granted.
    step(1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0, "t2_grant");
    for (int k = 0; k < 15; k++) step(1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0, "t2_hold");
    step(1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1, "t2_timeout");
    for (int k = 0; k < 3; k++) step(1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0, "t2_after");
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, "t2_release");

    // Contended: timeout hands the grant to requester 2.
    step(1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0, "t3_grant0");
    for (int k = 0; k < 15; k++) step(1'b1, 4'b0101, 4'b0001, 2'd0, 1'b0, "t3_hold0");
    step(1'b1, 4'b0101, 4'b0100, 2'd2, 1'b1, "t3_timeout_move");
    step(1'b1, 4'b0101, 4'b0100, 2'd2, 1'b0, "t3_hold2");
    step(1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0, "t3_back_to0");

    // Release hands over directly, no zero cycle.
    step(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0, "t4_grant2");
    step(1'b1, 4'b1000, 4'b1000, 2'd3, 1'b0, "t4_handover3");

    // Enable drop, then wrap search from 2 with last=1.
    step(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b0, "t5_grant1");
    step(1'b0, 4'b0011, 4'b0000, 2'd1, 1'b0, "t5_en_low");
    step(1'b1, 4'b0011, 4'b0001, 2'd0, 1'b0, "t5_wrap_grant0");

    // Release coinciding with the last allowed hold cycle: no timeout.
    for (int k = 0; k < 15; k++) step(1'b1, 4'b0011, 4'b0001, 2'd0, 1'b0, "b_hold0");
    step(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b0, "b_release_at_limit");
    step(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b0, "b_after_release");

    // Asynchronous reset between edges mid-grant.
    @(negedge clk);
    bus.en  = 1'b1;
    bus.req = 4'b1111;
    #1 rst_n = 1'b0;
    #1 check("t6_async_reset", observe(), mk(4'b0000, 2'd0, 1'b0));
    #1 rst_n = 1'b1;
    exp_q.push_back(mk(4'b0001, 2'd0, 1'b0));
    name_q.push_back("t6_first_after_reset");
    step(1'b1, 4'b1111, 4'b0001, 2'd0, 1'b0, "t6_hold0");

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d expected responses never compared", exp_q.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
